partial_fm_combiner: RTL
========================

Name: partial_fm_combiner

Overview:
- Consumer at the far end of the partial-feature-map interface. Accepts one frame of three Q1.15 partial feature maps (IK1, IK2, IK3) from the convolution stage.
- Sums the three maps element-wise, adds a per-frame bias and saturates the result.
- Streams the combined OP_SIZE x OP_SIZE map out one element per cycle over a valid/ready handshake. The output feeds the pooling/next-layer stage.

Parameters:
- IP_SIZE, 6, input feature map edge length.
- KERNEL_SIZE, 3, kernel edge length.
- OP_SIZE (localparam), IP_SIZE-KERNEL_SIZE+1, partial map edge length; element count N = OP_SIZE*OP_SIZE (16 at defaults).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- IK1  in  16*N  partial map 1, flattened; element i at [16*(i+1)-1 -: 16], i = row*OP_SIZE+col, signed Q1.15.
- IK2  in  16*N  partial map 2, same layout.
- IK3  in  16*N  partial map 3, same layout.
- bias  in  16  signed Q1.15 bias, sampled with the frame.
- in_valid  in  1  frame present on IK1..IK3 (driven from the producer's resting).
- in_ready  out  1  block can accept a frame.
- out_data  out  16  combined element, signed Q1.15.
- out_index  out  $clog2(N)  element index of out_data.
- out_last  out  1  out_data is element N-1.
- out_valid  out  1  out_data/out_index/out_last are valid.
- out_ready  in  1  downstream accepts the current element.
- frame_done  out  1  one-cycle pulse after the last element is accepted.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; in_ready=1; out_valid=0; out_data=0; out_index=0; out_last=0; frame_done=0; capture buffers cleared. Reset wins over every other event, including mid-stream; a partial frame is discarded.
- State IDLE: in_ready=1. On in_valid&&in_ready, latch IK1, IK2, IK3 and bias into internal buffers and go to LOAD. in_ready drops on the next cycle.
- State LOAD: one cycle. Compute element 0 and register it into out_data. Set out_valid=1, out_index=0, out_last=(N==1), then go to STREAM. Accept-to-first-out_valid latency: out_valid is high after the second edge following acceptance.
- State STREAM: outputs held stable while out_valid&&!out_ready (no change to data, index or last).
  - On handshake with out_last=0: register the next element and increment out_index.
  - On handshake with out_last=1: out_valid=0, frame_done=1 for one cycle, in_ready=1, go to IDLE.
- Frame throughput: N+2 cycles per frame with out_ready held high. No new frame is accepted before frame_done.
- in_valid outside IDLE is ignored. Buffered data is immune to changes on IK1..IK3 after capture.
- Arithmetic: sign-extend each term to 18 bits; sum = IK1[i]+IK2[i]+IK3[i]+bias (18-bit signed, cannot overflow). Saturate to 16 bits: >32767 gives 32767, <-32768 gives -32768.
- out_index wraps to 0 only via the IDLE→LOAD path. It never exceeds N-1.

Optional Feature:
- Macro PARTIAL_FM_RELU_EN.
- Defined: after saturation, negative results output 0 (ReLU); non-negative values pass unchanged.
- Undefined: the saturated signed sum passes unchanged.
- Latency and handshake are identical in both builds.

Test Plan:
- Basic sum: all IK1=4096, IK2=-2048, IK3=1024, bias=0, out_ready=1 → 16 elements of 3072; out_index 0..15; out_last only at 15; frame_done pulses once; in_ready high the cycle after.
- Positive saturation: all IK1=IK2=IK3=20000, bias=1000 → every out_data=32767.
- Negative case: all IK1=IK2=IK3=-20000, bias=0 → out_data=-32768 without PARTIAL_FM_RELU_EN, 0 with it. Mixed element (IK1=100, IK2=-300, IK3=0) → -200 without the macro, 0 with it.
- Backpressure: row-major ramp IKn[i]=i*16, bias=0; out_ready low for 5 cycles at out_index=7 → out_data=336, out_index=7 held stable throughout; stream resumes at index 8 (out_data 384) with no loss or duplication.
- Input stability: change IK1..IK3 and toggle in_valid during STREAM → output matches the captured frame; the second frame is accepted only after frame_done.
- Reset mid-stream: assert rst when out_index=7 → next cycle out_valid=0, in_ready=1, out_index=0, frame_done=0. A fresh frame afterwards streams correctly from index 0.

Source files
------------

// File: rtl/partial_fm_combiner_if.sv
// Frame-in / element-out bus for partial_fm_combiner.
// The producer side drives IK1..IK3, bias, in_valid and out_ready; the combiner drives the rest.
interface partial_fm_combiner_if #(
    parameter int IP_SIZE     = 6,
    parameter int KERNEL_SIZE = 3
);
    localparam int OP_SIZE = IP_SIZE - KERNEL_SIZE + 1;
    localparam int N       = OP_SIZE * OP_SIZE;
    localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;

    logic [16*N-1:0]  IK1;
    logic [16*N-1:0]  IK2;
    logic [16*N-1:0]  IK3;
    logic [15:0]      bias;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      out_data;
    logic [IDX_W-1:0] out_index;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;
    logic             frame_done;

    modport master (
        output IK1, IK2, IK3, bias, in_valid, out_ready,
        input  in_ready, out_data, out_index, out_last, out_valid, frame_done
    );

    modport slave (
        input  IK1, IK2, IK3, bias, in_valid, out_ready,
        output in_ready, out_data, out_index, out_last, out_valid, frame_done
    );
endinterface

// File: rtl/partial_fm_combiner.sv
// Sums three captured Q1.15 partial maps plus bias, saturates, and streams one element per cycle.
// Optional PARTIAL_FM_RELU_EN clamps negative saturated results to zero.
module partial_fm_combiner #(
    parameter int IP_SIZE     = 6,
    parameter int KERNEL_SIZE = 3
) (
    input logic                  clk,
    input logic                  rst,
    partial_fm_combiner_if.slave bus
);
    localparam int OP_SIZE = IP_SIZE - KERNEL_SIZE + 1;
    localparam int N       = OP_SIZE * OP_SIZE;
    localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM
    } state_t;

    state_t           state_q, state_d;
    logic [16*N-1:0]  ik1_q, ik1_d;
    logic [16*N-1:0]  ik2_q, ik2_d;
    logic [16*N-1:0]  ik3_q, ik3_d;
    logic [15:0]      bias_q, bias_d;
    logic [15:0]      data_q, data_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             last_q, last_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    int unsigned      elem_sel;
    logic [15:0]      elem;

    function automatic logic [15:0] combine(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c, input logic [15:0] d);
        logic signed [17:0] s;
        logic [15:0]        r;
        s = 18'(signed'(a)) + 18'(signed'(b)) + 18'(signed'(c)) + 18'(signed'(d));
        if (s > 18'sd32767) begin
            r = 16'h7FFF;
        end else if (s < -18'sd32768) begin
            r = 16'h8000;
        end else begin
            r = s[15:0];
        end
`ifdef PARTIAL_FM_RELU_EN
        if (r[15]) begin
            r = '0;
        end
`endif
        return r;
    endfunction

    // Element evaluated this cycle: 0 in LOAD, the successor of out_index while streaming.
    always_comb begin
        elem_sel = 0;
        if (state_q == STREAM) begin
            elem_sel = last_q ? 32'(idx_q) : 32'(idx_q) + 32'd1;
        end
        elem = combine(ik1_q[16*elem_sel +: 16], ik2_q[16*elem_sel +: 16],
                       ik3_q[16*elem_sel +: 16], bias_q);
    end

    always_comb begin
        state_d = state_q;
        ik1_d   = ik1_q;
        ik2_d   = ik2_q;
        ik3_d   = ik3_q;
        bias_d  = bias_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    ik1_d   = bus.IK1;
                    ik2_d   = bus.IK2;
                    ik3_d   = bus.IK3;
                    bias_d  = bus.bias;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                data_d  = elem;
                idx_d   = '0;
                last_d  = (N == 1);
                valid_d = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                if (bus.out_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        data_d = elem;
                        idx_d  = idx_q + IDX_W'(1);
                        last_d = (idx_q + IDX_W'(1)) == IDX_W'(N - 1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ik1_q   <= '0;
            ik2_q   <= '0;
            ik3_q   <= '0;
            bias_q  <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ik1_q   <= ik1_d;
            ik2_q   <= ik2_d;
            ik3_q   <= ik3_d;
            bias_q  <= bias_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_data   = data_q;
    assign bus.out_index  = idx_q;
    assign bus.out_last   = last_q;
    assign bus.out_valid  = valid_q;
    assign bus.frame_done = done_q;
endmodule
